// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM states, latched transfer configuration
// and slave-select decode.
package spi_pkg;

  localparam int unsigned DivMaxW = 32;
  localparam int unsigned SsMaxW  = 4;

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, FIN} spi_state_t;

  typedef struct packed {
    logic               cpol;
    logic               cpha;
    logic [DivMaxW-1:0] div;
    logic [SsMaxW-1:0]  ss_addr;
  } spi_cfg_t;

  function automatic logic [2**SsMaxW-1:0] onehot_ss(input logic [SsMaxW-1:0] addr);
    onehot_ss       = '0;
    onehot_ss[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: divides clk by div+1 per half-period, toggles SCLK during XFER and flags
// leading/trailing edges plus the final edge of the word.
module spi_clk_gen #(
  parameter int unsigned div_width  = 8,
  parameter int unsigned edge_width = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  xfer,
  input  logic [div_width-1:0]  div,
  input  logic                  cpol,
  input  logic [edge_width-1:0] edges_total,
  output logic                  sclk,
  output logic                  tick,
  output logic                  lead_stb,
  output logic                  trail_stb,
  output logic                  last_edge
);

  logic [div_width-1:0]  cnt_q;
  logic [edge_width-1:0] edge_q;
  logic                  sclk_q;

  // Counter wraps at div, so div = all-ones never overflows.
  assign tick      = run && (cnt_q == div);
  assign lead_stb  = xfer && tick && !edge_q[0];
  assign trail_stb = xfer && tick && edge_q[0];
  assign last_edge = xfer && tick && (edge_q == edges_total - 1'b1);
  assign sclk      = sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      edge_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      if (!run || tick) cnt_q <= '0;
      else              cnt_q <= cnt_q + 1'b1;

      if (!xfer)     edge_q <= '0;
      else if (tick) edge_q <= edge_q + 1'b1;

      if (!xfer)     sclk_q <= cpol;
      else if (tick) sclk_q <= ~sclk_q;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master with programmable SCLK divider, all four CPOL/CPHA modes, multi-lane data and
// a one-hot slave select, driven by a START/READY handshake with a one-cycle DONE pulse.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned word_width    = 8,
  parameter int unsigned send_width    = 1,
  parameter int unsigned SS_addr_width = 2,
  parameter int unsigned div_width     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        START,
  output logic                        READY,
  input  logic                        CPOL,
  input  logic                        CPHA,
  input  logic [div_width-1:0]        DIV,
  input  logic [SS_addr_width-1:0]    SS_ADDR,
  input  logic [word_width-1:0]       D_IN,
  input  logic                        ABORT,
  output logic [word_width-1:0]       D_OUT,
  output logic                        DONE,
  output logic                        SCLK,
  output logic [send_width-1:0]       SD_OUT,
  input  logic [send_width-1:0]       SD_IN,
  output logic [2**SS_addr_width-1:0] SS_OUT
);

  localparam int unsigned Beats  = word_width / send_width;
  localparam int unsigned EdgeW  = $clog2(2 * Beats + 1);
  localparam int unsigned Slaves = 2 ** SS_addr_width;

  if (word_width % send_width != 0) begin : g_width_check
    $fatal(1, "word_width must be a multiple of send_width");
  end
  if (SS_addr_width > SsMaxW || div_width > DivMaxW) begin : g_range_check
    $fatal(1, "SS_addr_width or div_width exceeds package limits");
  end

  spi_state_t              state_q, state_d;
  spi_cfg_t                cfg_q, cfg_in;
  logic [word_width-1:0]   tx_q, rx_q, d_out_q;
  logic                    first_q;
  logic                    accept, active, run, xfer, gen_cpol;
  logic                    tick, lead_stb, trail_stb, last_edge, tx_shift, rx_shift;
  logic [2**SsMaxW-1:0]    ss_full;
  logic                    unused_cfg;

  assign cfg_in = '{cpol: CPOL, cpha: CPHA, div: DivMaxW'(DIV), ss_addr: SsMaxW'(SS_ADDR)};
  assign accept = (state_q == IDLE) && START && !ABORT;
  assign active = (state_q == LEAD) || (state_q == XFER) || (state_q == TRAIL);
  // ABORT reaches the divider directly so SCLK returns to CPOL on the aborting edge.
  assign run      = active && !ABORT;
  assign xfer     = (state_q == XFER) && !ABORT;
  assign gen_cpol = (state_q == IDLE) ? CPOL : cfg_q.cpol;
  assign ss_full  = onehot_ss(cfg_q.ss_addr);
  assign unused_cfg = ^{cfg_q.div, ss_full};

  // CPHA=1 presents the first beat during LEAD, so the first leading edge must not shift.
  assign tx_shift = cfg_q.cpha ? (lead_stb && !first_q) : trail_stb;
  assign rx_shift = cfg_q.cpha ? trail_stb : lead_stb;

  spi_clk_gen #(
    .div_width (div_width),
    .edge_width(EdgeW)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .xfer       (xfer),
    .div        (cfg_q.div[div_width-1:0]),
    .cpol       (gen_cpol),
    .edges_total(EdgeW'(2 * Beats)),
    .sclk       (SCLK),
    .tick       (tick),
    .lead_stb   (lead_stb),
    .trail_stb  (trail_stb),
    .last_edge  (last_edge)
  );

  always_comb begin
    state_d = state_q;
    READY   = 1'b0;
    DONE    = 1'b0;
    SS_OUT  = '0;
    unique case (state_q)
      IDLE: begin
        READY = 1'b1;
        if (accept) state_d = LEAD;
      end
      LEAD: begin
        SS_OUT = ss_full[Slaves-1:0];
        if (ABORT)     state_d = IDLE;
        else if (tick) state_d = XFER;
      end
      XFER: begin
        SS_OUT = ss_full[Slaves-1:0];
        if (ABORT)          state_d = IDLE;
        else if (last_edge) state_d = TRAIL;
      end
      TRAIL: begin
        SS_OUT = ss_full[Slaves-1:0];
        if (ABORT)     state_d = IDLE;
        else if (tick) state_d = FIN;
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      d_out_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cfg_q   <= cfg_in;
        tx_q    <= D_IN;
        rx_q    <= '0;
        first_q <= 1'b1;
      end else begin
        if (tx_shift) tx_q <= tx_q << send_width;
        if (rx_shift) rx_q <= (rx_q << send_width) | word_width'(SD_IN);
        if (lead_stb) first_q <= 1'b0;
      end
      // Loaded on entry to FIN so D_OUT is already valid while DONE is high.
      if ((state_q == TRAIL) && (state_d == FIN)) d_out_q <= rx_q;
    end
  end

  assign D_OUT  = d_out_q;
  assign SD_OUT = tx_q[word_width-1 -: send_width];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed and randomized checks of spi_master_ctrl against a behavioural SPI slave and
// transfer-level expectations (captured words, latency, SCLK half-period, select line).
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, cpol, cpha, ready, done, sclk;
  logic [7:0] div, d_in, d_out;
  logic [1:0] ss_addr;
  logic [0:0] sd_out, sd_in;
  logic [3:0] ss_out;

  logic       start2, ready2, done2, sclk2;
  logic [7:0] d_in2, d_out2;
  logic [1:0] sd_out2, sd_in2;
  logic [3:0] ss_out2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(
    .word_width(8), .send_width(1), .SS_addr_width(2), .div_width(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .START(start), .READY(ready), .CPOL(cpol), .CPHA(cpha),
    .DIV(div), .SS_ADDR(ss_addr), .D_IN(d_in), .ABORT(abort), .D_OUT(d_out), .DONE(done),
    .SCLK(sclk), .SD_OUT(sd_out), .SD_IN(sd_in), .SS_OUT(ss_out)
  );

  spi_master_ctrl #(
    .word_width(8), .send_width(2), .SS_addr_width(2), .div_width(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .START(start2), .READY(ready2), .CPOL(1'b0), .CPHA(1'b1),
    .DIV(8'd1), .SS_ADDR(2'd0), .D_IN(d_in2), .ABORT(1'b0), .D_OUT(d_out2), .DONE(done2),
    .SCLK(sclk2), .SD_OUT(sd_out2), .SD_IN(sd_in2), .SS_OUT(ss_out2)
  );

  // Behavioural single-lane slave: returns s_word MSB first, captures MOSI into s_rx.
  logic [7:0] s_word, s_rx;
  logic [3:0] s_ss;
  logic       s_cpha;
  int         s_edges, s_bit;
  longint     s_last, s_hmin, s_hmax, s_hp;

  always @(ss_out) begin
    if (ss_out != 4'b0) begin
      s_edges = 0;
      s_rx    = 8'h00;
      s_ss    = ss_out;
      s_hmin  = 1000000;
      s_hmax  = 0;
      s_bit   = s_cpha ? 8 : 7;
      sd_in   = s_cpha ? 1'b0 : s_word[7];
    end
  end

  always @(sclk) begin
    if (ss_out != 4'b0) begin
      if (s_edges > 0) begin
        s_hp = ($time - s_last) / 10;
        if (s_hp < s_hmin) s_hmin = s_hp;
        if (s_hp > s_hmax) s_hmax = s_hp;
      end
      s_last = $time;
      if (((s_edges % 2) == 0) != s_cpha) begin
        s_rx = {s_rx[6:0], sd_out};
      end else begin
        s_bit--;
        sd_in = (s_bit >= 0) ? s_word[s_bit] : 1'b0;
      end
      s_edges++;
    end
  end

  // Dual-lane observer (mode 1): records MOSI beats on trailing edges.
  int         s2_edges;
  logic [1:0] s2_beats[$];

  always @(ss_out2) begin
    if (ss_out2 != 4'b0) begin
      s2_edges = 0;
      s2_beats.delete();
    end
  end

  always @(sclk2) begin
    if (ss_out2 != 4'b0) begin
      if ((s2_edges % 2) == 1) s2_beats.push_back(sd_out2);
      s2_edges++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output longint t);
    t = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t = $time;
        break;
      end
    end
  endtask

  task automatic begin_xfer(input logic pol, input logic pha, input logic [7:0] dv,
                            input logic [1:0] sa, input logic [7:0] din, input logic [7:0] sw,
                            output longint acc);
    @(negedge clk);
    cpol = pol; cpha = pha; div = dv; ss_addr = sa; d_in = din; start = 0; abort = 0;
    s_word = sw; s_cpha = pha;
    @(negedge clk);
    check("idle_ready", ready, 1);
    check("idle_sclk", sclk, pol);
    check("idle_ss", ss_out, 0);
    start = 1;
    @(posedge clk);
    acc = $time;
    @(negedge clk);
    start = 0;
    check("accept_ready", ready, 0);
    // Mid-transfer input changes must not affect the transfer in flight.
    cpol = ~pol; cpha = ~pha; div = 8'($urandom); ss_addr = sa + 2'd1; d_in = ~din;
  endtask

  task automatic finish_xfer(input longint acc, input logic pol, input logic [7:0] dv,
                             input logic [1:0] sa, input logic [7:0] din, input logic [7:0] sw);
    longint t;
    int     lat;
    lat = (int'(dv) + 1) * 18;
    wait_done(t);
    check("done_latency", (t < 0) ? 32'hFFFF_FFFF : 32'((t - 5 - acc) / 10), lat);
    check("fin_ss", ss_out, 0);
    check("fin_ready", ready, 0);
    check("fin_sclk", sclk, pol);
    check("sclk_edges", s_edges, 16);
    check("half_min", 32'(s_hmin), dv + 1);
    check("half_max", 32'(s_hmax), dv + 1);
    check("ss_onehot", s_ss, 32'd1 << sa);
    check("slave_rx", s_rx, din);
    @(negedge clk);
    check("done_width", done, 0);
    check("ready_back", ready, 1);
    check("d_out", d_out, sw);
  endtask

  longint     acc_t, dt;
  int         cnt;
  logic       r_pol, r_pha;
  logic [7:0] r_div, r_din, r_sw;
  logic [1:0] r_sa;

  initial begin
    rst_n = 0; start = 0; abort = 0; cpol = 0; cpha = 0; div = 0; ss_addr = 0; d_in = 0;
    start2 = 0; d_in2 = 0; sd_in2 = 2'b10; s_word = 0; s_cpha = 0; sd_in = 0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_dout", d_out, 0);
    check("rst_sclk", sclk, 0);
    check("rst_sdout", sd_out, 0);
    check("rst_ss", ss_out, 0);
    @(negedge clk);
    rst_n = 1;

    // Mode 0, DIV=0, slave 2
    begin_xfer(0, 0, 8'd0, 2'd2, 8'hA5, 8'h3C, acc_t);
    finish_xfer(acc_t, 0, 8'd0, 2'd2, 8'hA5, 8'h3C);

    // Abort after the third XFER edge
    begin_xfer(0, 0, 8'd1, 2'd1, 8'h96, 8'hFF, acc_t);
    for (int i = 0; i < 200 && s_edges < 3; i++) @(negedge clk);
    check("abort_edges", s_edges, 3);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort_ss", ss_out, 0);
    check("abort_sclk", sclk, 0);
    check("abort_ready", ready, 1);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done !== 1'b0) cnt++;
    end
    check("abort_no_done", cnt, 0);
    check("abort_dout", d_out, 8'h3C);

    // Mode 3, DIV=2
    begin_xfer(1, 1, 8'd2, 2'd0, 8'h81, 8'h7E, acc_t);
    finish_xfer(acc_t, 1, 8'd2, 2'd0, 8'h81, 8'h7E);

    // Dual lane, mode 1, DIV=1
    @(negedge clk);
    d_in2 = 8'hE4; start2 = 1;
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    start2 = 0; d_in2 = 8'h00;
    dt = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done2 === 1'b1) begin
        dt = $time;
        break;
      end
    end
    check("dual_latency", (dt < 0) ? 32'hFFFF_FFFF : 32'((dt - 5 - acc_t) / 10), 20);
    check("dual_edges", s2_edges, 8);
    check("dual_beats", s2_beats.size(), 4);
    for (int i = 0; i < 4 && i < s2_beats.size(); i++) check("dual_beat", s2_beats[i], 3 - i);
    @(negedge clk);
    check("dual_dout", d_out2, 8'hAA);
    check("dual_ready", ready2, 1);

    // Mid-transfer START pulse is ignored
    begin_xfer(0, 0, 8'd0, 2'd1, 8'h11, 8'h22, acc_t);
    repeat (4) @(negedge clk);
    start = 1; d_in = 8'h99;
    @(negedge clk);
    start = 0;
    finish_xfer(acc_t, 0, 8'd0, 2'd1, 8'h11, 8'h22);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (ss_out != 4'b0 || ready !== 1'b1) cnt++;
    end
    check("start_not_queued", cnt, 0);

    // START held high: back-to-back transfers separated by one IDLE cycle
    @(negedge clk);
    cpol = 0; cpha = 1; div = 8'd1; ss_addr = 2'd3; d_in = 8'hC3;
    s_word = 8'h5C; s_cpha = 1; start = 1;
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    d_in = 8'h3A;
    wait_done(dt);
    check("held1_latency", (dt < 0) ? 32'hFFFF_FFFF : 32'((dt - 5 - acc_t) / 10), 36);
    check("held1_rx", s_rx, 8'hC3);
    s_word = 8'hA7;
    @(negedge clk);
    check("held1_dout", d_out, 8'h5C);
    check("held_idle_gap", ready, 1);
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    start = 0;
    check("held2_accept", ready, 0);
    check("held2_ss", ss_out, 4'b1000);
    finish_xfer(acc_t, 0, 8'd1, 2'd3, 8'h3A, 8'hA7);

    // START with ABORT in IDLE
    @(negedge clk);
    start = 1; abort = 1;
    repeat (3) begin
      @(negedge clk);
      check("startabort_ready", ready, 1);
      check("startabort_ss", ss_out, 0);
    end
    start = 0; abort = 0;

    // Asynchronous reset mid-XFER
    begin_xfer(1, 0, 8'd2, 2'd2, 8'hFF, 8'h00, acc_t);
    for (int i = 0; i < 200 && s_edges < 4; i++) @(negedge clk);
    check("rst_wait_edges", s_edges, 4);
    #2 rst_n = 0;
    #1;
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_ss", ss_out, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_dout", d_out, 0);
    check("mid_rst_sdout", sd_out, 0);
    @(negedge clk);
    rst_n = 1;
    begin_xfer(0, 0, 8'd1, 2'd0, 8'h5A, 8'hC6, acc_t);
    finish_xfer(acc_t, 0, 8'd1, 2'd0, 8'h5A, 8'hC6);

    // Randomized transfers
    for (int k = 0; k < 6; k++) begin
      r_pol = 1'($urandom_range(0, 1));
      r_pha = 1'($urandom_range(0, 1));
      r_div = 8'($urandom_range(0, 3));
      r_sa  = 2'($urandom_range(0, 3));
      r_din = 8'($urandom);
      r_sw  = 8'($urandom);
      begin_xfer(r_pol, r_pha, r_div, r_sa, r_din, r_sw, acc_t);
      finish_xfer(acc_t, r_pol, r_div, r_sa, r_din, r_sw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
